// File: rtl/neuron_pkg.sv
// Shared constants, FSM state encoding and sign-extension helper for the neuron accumulator.
// Latency: n/a (declarations only); backpressure: n/a.
package neuron_pkg;

  localparam int SM_W  = 10;
  localparam int MAG_W = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Sign-extends a 10-bit two's-complement value; bits at or above acc_w are zeroed.
  function automatic logic [31:0] sm_sext(input logic [SM_W-1:0] value, input int acc_w);
    logic [31:0] r;
    r = {{(32-SM_W){value[SM_W-1]}}, value};
    for (int i = 0; i < 32; i++) begin
      if (i >= acc_w) r[i] = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/sm_to_tc.sv
// Converts a 10-bit sign-magnitude value to two's complement; negative zero maps to 0.
// Latency: combinational; backpressure: none.
module sm_to_tc
  import neuron_pkg::*;
(
  input  logic [SM_W-1:0] sm,
  output logic [SM_W-1:0] tc
);

  logic [MAG_W-1:0] mag;
  assign mag = sm[MAG_W-1:0];

  always_comb begin
    tc = '0;
    if (!sm[SM_W-1]) begin
      tc = {1'b0, mag};
    end else if (mag != '0) begin
      tc = {1'b1, ~mag} + SM_W'(1);
    end
  end

endmodule

// File: rtl/neuron_acc_seq.sv
// Accumulates N_INPUTS sign-magnitude products into one neuron sum (NEURON_ACC_SATURATE_EN selects clamping).
// Latency: out_valid the cycle after the last input beat; N_INPUTS+1 cycles from start at minimum.
// Backpressure: in_ready only while accumulating; result and overflow held in DONE until out_ready.
module neuron_acc_seq
  import neuron_pkg::*;
#(
  parameter int N_INPUTS = 8,
  parameter int ACC_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SM_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             overflow
);

  localparam int CNT_W = $clog2(N_INPUTS) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_INPUTS - 1);

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] count;

  logic [SM_W-1:0]  tc_val;
  logic [ACC_W-1:0] ext;
  logic [ACC_W-1:0] sum;
  logic [ACC_W-1:0] nxt_acc;
  logic             add_ovf;
  logic             hs;

  sm_to_tc u_conv (
    .sm (in_data),
    .tc (tc_val)
  );

  assign ext     = ACC_W'(sm_sext(tc_val, ACC_W));
  assign sum     = acc + ext;
  assign add_ovf = (acc[ACC_W-1] == ext[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);
  assign hs      = in_valid & in_ready;

`ifdef NEURON_ACC_SATURATE_EN
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  // Both operands share a sign on overflow, so the accumulator sign picks the rail.
  assign nxt_acc = add_ovf ? (acc[ACC_W-1] ? ACC_MIN : ACC_MAX) : sum;
`else
  assign nxt_acc = sum;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      count     <= '0;
      busy      <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= ACCUM;
            acc      <= '0;
            count    <= '0;
            overflow <= 1'b0;
            busy     <= 1'b1;
            in_ready <= 1'b1;
          end
        end
        ACCUM: begin
          if (hs) begin
            acc   <= nxt_acc;
            count <= count + CNT_W'(1);
            if (add_ovf) overflow <= 1'b1;
            if (count == LAST) begin
              state     <= DONE;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              out_data  <= nxt_acc;
            end
          end
        end
        DONE: begin
          // A coincident start is dropped: the block only listens to start in IDLE.
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_acc_seq.sv
// Directed and randomized checks of neuron_acc_seq against an integer reference model.
module tb_neuron_acc_seq;

  logic clk = 1'b0;
  logic rst_n;

  // Instance a: N_INPUTS=4, ACC_W=16
  logic        start_a, in_valid_a, out_ready_a;
  logic [9:0]  in_data_a;
  logic        busy_a, in_ready_a, out_valid_a, overflow_a;
  logic [15:0] out_data_a;
  // Instance b: N_INPUTS=2, ACC_W=10
  logic        start_b, in_valid_b, out_ready_b;
  logic [9:0]  in_data_b;
  logic        busy_b, in_ready_b, out_valid_b, overflow_b;
  logic [9:0]  out_data_b;

  int vectors = 0;
  int miscompares = 0;
  logic [9:0] stim[$];

  always #5 clk = ~clk;

  neuron_acc_seq #(.N_INPUTS(4), .ACC_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .busy(busy_a),
    .in_valid(in_valid_a), .in_ready(in_ready_a), .in_data(in_data_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a), .out_data(out_data_a),
    .overflow(overflow_a)
  );

  neuron_acc_seq #(.N_INPUTS(2), .ACC_W(10)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .busy(busy_b),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
    .overflow(overflow_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic drive(input int w, input logic st, input logic iv, input logic [9:0] id,
                       input logic ordy);
    if (w == 0) begin
      start_a = st; in_valid_a = iv; in_data_a = id; out_ready_a = ordy;
    end else begin
      start_b = st; in_valid_b = iv; in_data_b = id; out_ready_b = ordy;
    end
  endtask

  task automatic sample(input int w, output logic [31:0] od, output logic ov, output logic of,
                        output logic ir, output logic bs);
    if (w == 0) begin
      od = {16'b0, out_data_a}; ov = out_valid_a; of = overflow_a; ir = in_ready_a; bs = busy_a;
    end else begin
      od = {22'b0, out_data_b}; ov = out_valid_b; of = overflow_b; ir = in_ready_b; bs = busy_b;
    end
  endtask

  // Reference: plain signed integer sum, range-checked against ACC_W after every addition.
  function automatic void model(input int wid, output int res, output bit ovf);
    int mx, mn, acc, v;
    mx = (1 << (wid - 1)) - 1;
    mn = -(1 << (wid - 1));
    acc = 0;
    ovf = 1'b0;
    foreach (stim[i]) begin
      v = stim[i][9] ? -int'(stim[i][8:0]) : int'(stim[i][8:0]);
      acc = acc + v;
      if (acc > mx || acc < mn) begin
        ovf = 1'b1;
`ifdef NEURON_ACC_SATURATE_EN
        acc = (acc > mx) ? mx : mn;
`else
        acc = (acc > mx) ? acc - (1 << wid) : acc + (1 << wid);
`endif
      end
    end
    res = acc;
  endfunction

  // gapmode: 0 none, 1 idle cycle before every beat, 2 random idle cycles.
  // Stray start pulses accompany every idle/hold cycle and the final out handshake.
  task automatic run(input int w, input int gapmode, input int hold,
                     input logic [31:0] exp_d, input logic exp_o, input string tag);
    logic [31:0] od;
    logic ov, of, ir, bs;
    drive(w, 1'b1, 1'b0, 10'h0, 1'b0);
    @(negedge clk);
    drive(w, 1'b0, 1'b0, 10'h0, 1'b0);
    @(negedge clk);
    sample(w, od, ov, of, ir, bs);
    chk1({tag, ".busy"}, bs, 1'b1);
    chk1({tag, ".in_ready"}, ir, 1'b1);
    foreach (stim[i]) begin
      if (gapmode == 1 || (gapmode == 2 && $urandom_range(1) == 1)) begin
        drive(w, 1'b1, 1'b0, 10'h3FF, 1'b0);
        @(negedge clk);
      end
      drive(w, 1'b0, 1'b1, stim[i], 1'b0);
      if (i == stim.size() - 1) begin
        sample(w, od, ov, of, ir, bs);
        chk1({tag, ".early_valid"}, ov, 1'b0);
      end
      @(negedge clk);
    end
    drive(w, 1'b0, 1'b0, 10'h0, 1'b0);
    sample(w, od, ov, of, ir, bs);
    chk1({tag, ".out_valid"}, ov, 1'b1);
    chk({tag, ".out_data"}, od, exp_d);
    chk1({tag, ".overflow"}, of, exp_o);
    for (int k = 0; k < hold; k++) begin
      drive(w, 1'b1, 1'b0, 10'h0, 1'b0);
      @(negedge clk);
      sample(w, od, ov, of, ir, bs);
      chk1({tag, ".hold_valid"}, ov, 1'b1);
      chk({tag, ".hold_data"}, od, exp_d);
      chk1({tag, ".hold_ovf"}, of, exp_o);
    end
    drive(w, 1'b1, 1'b0, 10'h0, 1'b1);
    @(negedge clk);
    drive(w, 1'b0, 1'b0, 10'h0, 1'b0);
    sample(w, od, ov, of, ir, bs);
    chk1({tag, ".done_valid"}, ov, 1'b0);
    chk1({tag, ".idle_busy"}, bs, 1'b0);
    chk({tag, ".kept_data"}, od, exp_d);
    chk1({tag, ".kept_ovf"}, of, exp_o);
  endtask

  initial begin
    logic [31:0] od;
    logic ov, of, ir, bs;
    int res, wsel;
    bit ovf;
    logic [31:0] mask;

    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, 10'h0, 1'b0);
    drive(1, 1'b0, 1'b0, 10'h0, 1'b0);
    @(negedge clk);
    for (int w = 0; w < 2; w++) begin
      sample(w, od, ov, of, ir, bs);
      chk("rst.out_data", od, 32'h0);
      chk1("rst.out_valid", ov, 1'b0);
      chk1("rst.overflow", of, 1'b0);
      chk1("rst.in_ready", ir, 1'b0);
      chk1("rst.busy", bs, 1'b0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    stim = '{10'h003, 10'h205, 10'h064, 10'h201};
    run(0, 0, 0, 32'h0061, 1'b0, "basic");
    run(0, 1, 5, 32'h0061, 1'b0, "gaps");

    stim = '{10'h200, 10'h005};
    run(1, 0, 0, 32'h005, 1'b0, "negzero");
    stim = '{10'h3FF, 10'h1FF};
    run(1, 0, 1, 32'h000, 1'b0, "extremes");
    stim = '{10'h1FF, 10'h1FF};
`ifdef NEURON_ACC_SATURATE_EN
    run(1, 0, 2, 32'h1FF, 1'b1, "ovf_sat");
`else
    run(1, 0, 2, 32'h3FE, 1'b1, "ovf_wrap");
`endif
    // The next accepted start clears the sticky overflow.
    stim = '{10'h001, 10'h002};
    run(1, 0, 0, 32'h003, 1'b0, "ovf_clear");

    // Abort after two of four beats.
    drive(0, 1'b1, 1'b0, 10'h0, 1'b0);
    @(negedge clk);
    drive(0, 1'b0, 1'b1, 10'h007, 1'b0);
    @(negedge clk);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 10'h0, 1'b0);
    rst_n = 1'b0;
    #1;
    sample(0, od, ov, of, ir, bs);
    chk1("midrst.busy", bs, 1'b0);
    chk1("midrst.in_ready", ir, 1'b0);
    chk("midrst.out_data", od, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      sample(0, od, ov, of, ir, bs);
      chk1("midrst.no_valid", ov, 1'b0);
    end
    stim = '{10'h001, 10'h001, 10'h001, 10'h001};
    run(0, 0, 0, 32'h0004, 1'b0, "after_rst");

    for (int r = 0; r < 16; r++) begin
      wsel = int'($urandom_range(1));
      stim.delete();
      for (int j = 0; j < ((wsel == 0) ? 4 : 2); j++) stim.push_back(10'($urandom));
      model((wsel == 0) ? 16 : 10, res, ovf);
      mask = (wsel == 0) ? 32'hFFFF : 32'h3FF;
      run(wsel, 2, int'($urandom_range(3)), 32'(res) & mask, ovf, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
